// File: rtl/pinball_game_ctrl_pkg.sv
// Shared game-state codes and widths for the pinball game sequencer.
// The state codes are also decoded by the group-select and display blocks.
package pinball_game_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int GROUP_W = 3;
    localparam int BALLS_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_GET   = 3'd3,
        ST_OVER  = 3'd4
    } game_state_e;

endpackage

// File: rtl/pinball_game_ctrl_if.sv
// Button inputs and game status outputs of the pinball sequencer.
// Inputs are single-cycle pulses; every output is registered in the controller.
interface pinball_game_ctrl_if #(
    parameter int SCORE_W = 14
);
    logic               flash_tick;
    logic               btn_start;
    logic               btn_down;
    logic [2:0]         state;
    logic [2:0]         flash_cnt;
    logic [2:0]         selected_group;
    logic [SCORE_W-1:0] score;
    logic [3:0]         balls_left;
    logic               score_pulse;

    modport master (
        output flash_tick, btn_start, btn_down,
        input  state, flash_cnt, selected_group, score, balls_left, score_pulse
    );

    modport slave (
        input  flash_tick, btn_start, btn_down,
        output state, flash_cnt, selected_group, score, balls_left, score_pulse
    );
endinterface

// File: rtl/pinball_game_ctrl_score_acc.sv
// Saturating score accumulator with a one-cycle pulse after each accepted add.
module pinball_score_acc #(
    parameter int SCORE_W = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               add_en_i,
    input  logic [SCORE_W-1:0] add_val_i,
    output logic [SCORE_W-1:0] score_o,
    output logic               score_pulse_o
);
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               pulse_q;

    always_comb begin
        sum     = {1'b0, score_q} + {1'b0, add_val_i};
        score_d = score_q;
        if (clear_i) begin
            score_d = '0;
        end else if (add_en_i) begin
            // Carry out of the top bit means the true sum exceeds the score range.
            score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            score_q <= score_d;
            pulse_q <= add_en_i;
        end
    end

    assign score_o       = score_q;
    assign score_pulse_o = pulse_q;
endmodule

// File: rtl/pinball_game_ctrl.sv
// Game sequencer: RESET -> WAIT -> START <-> GET -> OVER, with group cursor,
// hit latch, ball accounting and a saturating score accumulator.
module pinball_game_ctrl #(
    parameter int NUM_BALLS  = 3,
    parameter int GET_HOLD   = 4,
    parameter int POINT_STEP = 10,
    parameter int SCORE_W    = 14
) (
    input logic                clk,
    input logic                reset,
    pinball_game_ctrl_if.slave bus
);
    import pinball_game_ctrl_pkg::*;

    localparam int HOLD_W = (GET_HOLD > 1) ? $clog2(GET_HOLD) : 1;

    game_state_e        state_q, state_d;
    logic [GROUP_W-1:0] flash_q, flash_d;
    logic [GROUP_W-1:0] sel_q, sel_d;
    logic [BALLS_W-1:0] balls_q, balls_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               score_clear;
    logic               score_add_en;
    logic [SCORE_W-1:0] score_add_val;

    // Points for the group being hit are taken from the cursor on the hit edge.
    assign score_add_val = SCORE_W'(flash_q) * SCORE_W'(POINT_STEP);

    always_comb begin
        state_d      = state_q;
        flash_d      = flash_q;
        sel_d        = sel_q;
        balls_d      = balls_q;
        hold_d       = hold_q;
        score_clear  = 1'b0;
        score_add_en = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.btn_start) begin
                    state_d     = ST_START;
                    score_clear = 1'b1;
                    balls_d     = BALLS_W'(NUM_BALLS);
                    flash_d     = '0;
                end
            end
            ST_START: begin
                // A hit wins over a same-cycle flash tick: the cursor stays put.
                if (bus.btn_down) begin
                    state_d      = ST_GET;
                    sel_d        = flash_q;
                    balls_d      = balls_q - 1'b1;
                    score_add_en = 1'b1;
                end else if (bus.flash_tick) begin
                    flash_d = flash_q + 1'b1;
                end
            end
            ST_GET: begin
                if (bus.flash_tick) begin
                    if (hold_q == HOLD_W'(GET_HOLD - 1)) begin
                        sel_d   = '0;
                        hold_d  = '0;
                        state_d = (balls_q == '0) ? ST_OVER : ST_START;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (bus.btn_start) state_d = ST_WAIT;
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
            flash_q <= '0;
            sel_q   <= '0;
            balls_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            flash_q <= flash_d;
            sel_q   <= sel_d;
            balls_q <= balls_d;
            hold_q  <= hold_d;
        end
    end

    pinball_score_acc #(
        .SCORE_W(SCORE_W)
    ) u_score_acc (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (score_clear),
        .add_en_i     (score_add_en),
        .add_val_i    (score_add_val),
        .score_o      (bus.score),
        .score_pulse_o(bus.score_pulse)
    );

    assign bus.state          = state_q;
    assign bus.flash_cnt      = flash_q;
    assign bus.selected_group = sel_q;
    assign bus.balls_left     = balls_q;
endmodule

// File: tb/tb_pinball_game_ctrl.sv
// Directed bench for pinball_game_ctrl: default build plus a 7-bit score build
// used to reach saturation.
module tb_pinball_game_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pinball_game_ctrl_if #(.SCORE_W(14)) b  ();
    pinball_game_ctrl_if #(.SCORE_W(7))  b2 ();

    pinball_game_ctrl #(.NUM_BALLS(3), .GET_HOLD(4), .POINT_STEP(10), .SCORE_W(14)) dut (
        .clk(clk), .reset(reset), .bus(b)
    );

    pinball_game_ctrl #(.NUM_BALLS(3), .GET_HOLD(4), .POINT_STEP(10), .SCORE_W(7)) dut_sat (
        .clk(clk), .reset(reset), .bus(b2)
    );

    // Inputs change and outputs are sampled 1 ns after the active edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        b.flash_tick = 0; b.btn_start = 0; b.btn_down = 0;
        b2.flash_tick = 0; b2.btn_start = 0; b2.btn_down = 0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        n_cmp++; if (b.state !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", b.state); end
        n_cmp++; if (b.flash_cnt !== 3'd0) begin n_err++; $display("FAIL rst_flash: got %0d want 0", b.flash_cnt); end
        n_cmp++; if (b.selected_group !== 3'd0) begin n_err++; $display("FAIL rst_sel: got %0d want 0", b.selected_group); end
        n_cmp++; if (b.score !== 14'd0) begin n_err++; $display("FAIL rst_score: got %0d want 0", b.score); end
        n_cmp++; if (b.balls_left !== 4'd0) begin n_err++; $display("FAIL rst_balls: got %0d want 0", b.balls_left); end
        n_cmp++; if (b.score_pulse !== 1'b0) begin n_err++; $display("FAIL rst_pulse: got %0d want 0", b.score_pulse); end
        tick();
        n_cmp++; if (b.state !== 3'd1) begin n_err++; $display("FAIL reset_to_wait: got %0d want 1", b.state); end
        n_cmp++; if (b.score !== 14'd0) begin n_err++; $display("FAIL wait_score: got %0d want 0", b.score); end
        n_cmp++; if (b.balls_left !== 4'd0) begin n_err++; $display("FAIL wait_balls: got %0d want 0", b.balls_left); end
    endtask

    task automatic test_start();
        b.btn_down = 1; tick(); b.btn_down = 0;
        n_cmp++; if (b.state !== 3'd1) begin n_err++; $display("FAIL wait_ignores_down: got %0d want 1", b.state); end
        b.btn_start = 1; tick(); b.btn_start = 0;
        n_cmp++; if (b.state !== 3'd2) begin n_err++; $display("FAIL start_state: got %0d want 2", b.state); end
        n_cmp++; if (b.balls_left !== 4'd3) begin n_err++; $display("FAIL start_balls: got %0d want 3", b.balls_left); end
        n_cmp++; if (b.score !== 14'd0) begin n_err++; $display("FAIL start_score: got %0d want 0", b.score); end
        n_cmp++; if (b.flash_cnt !== 3'd0) begin n_err++; $display("FAIL start_flash: got %0d want 0", b.flash_cnt); end
        b.flash_tick = 1; tick(5); b.flash_tick = 0;
        n_cmp++; if (b.flash_cnt !== 3'd5) begin n_err++; $display("FAIL flash_5: got %0d want 5", b.flash_cnt); end
        b.btn_start = 1; tick(); b.btn_start = 0;
        n_cmp++; if (b.state !== 3'd2) begin n_err++; $display("FAIL start_ignores_start: got %0d want 2", b.state); end
    endtask

    task automatic test_hit();
        b.flash_tick = 1; b.btn_down = 1; tick(); b.flash_tick = 0; b.btn_down = 0;
        n_cmp++; if (b.state !== 3'd3) begin n_err++; $display("FAIL hit_state: got %0d want 3", b.state); end
        n_cmp++; if (b.selected_group !== 3'd5) begin n_err++; $display("FAIL hit_sel: got %0d want 5", b.selected_group); end
        n_cmp++; if (b.flash_cnt !== 3'd5) begin n_err++; $display("FAIL hit_flash_frozen: got %0d want 5", b.flash_cnt); end
        n_cmp++; if (b.score !== 14'd50) begin n_err++; $display("FAIL hit_score: got %0d want 50", b.score); end
        n_cmp++; if (b.balls_left !== 4'd2) begin n_err++; $display("FAIL hit_balls: got %0d want 2", b.balls_left); end
        n_cmp++; if (b.score_pulse !== 1'b1) begin n_err++; $display("FAIL hit_pulse: got %0d want 1", b.score_pulse); end
        tick();
        n_cmp++; if (b.score_pulse !== 1'b0) begin n_err++; $display("FAIL hit_pulse_end: got %0d want 0", b.score_pulse); end
    endtask

    task automatic test_get_hold();
        b.btn_start = 1; b.btn_down = 1; tick(); b.btn_start = 0; b.btn_down = 0;
        n_cmp++; if (b.state !== 3'd3) begin n_err++; $display("FAIL get_ignores_btns: got %0d want 3", b.state); end
        b.flash_tick = 1; tick(3);
        n_cmp++; if (b.state !== 3'd3) begin n_err++; $display("FAIL hold_3_state: got %0d want 3", b.state); end
        n_cmp++; if (b.selected_group !== 3'd5) begin n_err++; $display("FAIL hold_3_sel: got %0d want 5", b.selected_group); end
        n_cmp++; if (b.flash_cnt !== 3'd5) begin n_err++; $display("FAIL hold_flash: got %0d want 5", b.flash_cnt); end
        tick(); b.flash_tick = 0;
        n_cmp++; if (b.state !== 3'd2) begin n_err++; $display("FAIL hold_done_state: got %0d want 2", b.state); end
        n_cmp++; if (b.selected_group !== 3'd0) begin n_err++; $display("FAIL hold_done_sel: got %0d want 0", b.selected_group); end
    endtask

    task automatic test_game_over();
        b.flash_tick = 1; tick(3); b.flash_tick = 0;
        n_cmp++; if (b.flash_cnt !== 3'd0) begin n_err++; $display("FAIL flash_wrap: got %0d want 0", b.flash_cnt); end
        b.btn_down = 1; tick(); b.btn_down = 0;
        n_cmp++; if (b.score !== 14'd50) begin n_err++; $display("FAIL g0_score: got %0d want 50", b.score); end
        n_cmp++; if (b.balls_left !== 4'd1) begin n_err++; $display("FAIL g0_balls: got %0d want 1", b.balls_left); end
        n_cmp++; if (b.score_pulse !== 1'b1) begin n_err++; $display("FAIL g0_pulse: got %0d want 1", b.score_pulse); end
        b.flash_tick = 1; tick(4); b.flash_tick = 0;
        n_cmp++; if (b.state !== 3'd2) begin n_err++; $display("FAIL g0_back_start: got %0d want 2", b.state); end
        b.flash_tick = 1; tick(7); b.flash_tick = 0;
        b.btn_down = 1; tick(); b.btn_down = 0;
        n_cmp++; if (b.selected_group !== 3'd7) begin n_err++; $display("FAIL g7_sel: got %0d want 7", b.selected_group); end
        n_cmp++; if (b.score !== 14'd120) begin n_err++; $display("FAIL g7_score: got %0d want 120", b.score); end
        n_cmp++; if (b.balls_left !== 4'd0) begin n_err++; $display("FAIL g7_balls: got %0d want 0", b.balls_left); end
        b.flash_tick = 1; tick(4); b.flash_tick = 0;
        n_cmp++; if (b.state !== 3'd4) begin n_err++; $display("FAIL over_state: got %0d want 4", b.state); end
        b.btn_down = 1; tick(); b.btn_down = 0;
        n_cmp++; if (b.state !== 3'd4) begin n_err++; $display("FAIL over_ignores_down: got %0d want 4", b.state); end
        b.btn_start = 1; tick(); b.btn_start = 0;
        n_cmp++; if (b.state !== 3'd1) begin n_err++; $display("FAIL over_to_wait: got %0d want 1", b.state); end
        n_cmp++; if (b.score !== 14'd120) begin n_err++; $display("FAIL wait_keeps_score: got %0d want 120", b.score); end
    endtask

    task automatic test_reset_mid_get();
        b.btn_start = 1; b.btn_down = 1; tick(); b.btn_start = 0; b.btn_down = 0;
        n_cmp++; if (b.state !== 3'd2) begin n_err++; $display("FAIL both_in_wait: got %0d want 2", b.state); end
        n_cmp++; if (b.score !== 14'd0) begin n_err++; $display("FAIL new_game_score: got %0d want 0", b.score); end
        b.flash_tick = 1; tick(2); b.flash_tick = 0;
        b.btn_start = 1; b.btn_down = 1; tick(); b.btn_start = 0; b.btn_down = 0;
        n_cmp++; if (b.state !== 3'd3) begin n_err++; $display("FAIL both_in_start: got %0d want 3", b.state); end
        n_cmp++; if (b.score !== 14'd20) begin n_err++; $display("FAIL g2_score: got %0d want 20", b.score); end
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        n_cmp++; if (b.state !== 3'd0) begin n_err++; $display("FAIL mid_rst_state: got %0d want 0", b.state); end
        n_cmp++; if (b.score !== 14'd0) begin n_err++; $display("FAIL mid_rst_score: got %0d want 0", b.score); end
        n_cmp++; if (b.balls_left !== 4'd0) begin n_err++; $display("FAIL mid_rst_balls: got %0d want 0", b.balls_left); end
        n_cmp++; if (b.selected_group !== 3'd0) begin n_err++; $display("FAIL mid_rst_sel: got %0d want 0", b.selected_group); end
        n_cmp++; if (b.flash_cnt !== 3'd0) begin n_err++; $display("FAIL mid_rst_flash: got %0d want 0", b.flash_cnt); end
        n_cmp++; if (b.score_pulse !== 1'b0) begin n_err++; $display("FAIL mid_rst_pulse: got %0d want 0", b.score_pulse); end
        tick();
        n_cmp++; if (b.state !== 3'd1) begin n_err++; $display("FAIL mid_rst_to_wait: got %0d want 1", b.state); end
    endtask

    task automatic test_saturate();
        b2.btn_start = 1; tick(); b2.btn_start = 0;
        b2.flash_tick = 1; tick(7); b2.flash_tick = 0;
        b2.btn_down = 1; tick(); b2.btn_down = 0;
        n_cmp++; if (b2.score !== 7'd70) begin n_err++; $display("FAIL sat_first: got %0d want 70", b2.score); end
        b2.flash_tick = 1; tick(4); b2.flash_tick = 0;
        n_cmp++; if (b2.flash_cnt !== 3'd7) begin n_err++; $display("FAIL sat_flash: got %0d want 7", b2.flash_cnt); end
        b2.btn_down = 1; tick(); b2.btn_down = 0;
        n_cmp++; if (b2.score !== 7'd127) begin n_err++; $display("FAIL sat_score: got %0d want 127", b2.score); end
        n_cmp++; if (b2.score_pulse !== 1'b1) begin n_err++; $display("FAIL sat_pulse: got %0d want 1", b2.score_pulse); end
        n_cmp++; if (b2.balls_left !== 4'd1) begin n_err++; $display("FAIL sat_balls: got %0d want 1", b2.balls_left); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_get_hold();
        test_game_over();
        test_reset_mid_get();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
